// File: rtl/data_synchronizer.sv
// Moves a level-qualified data bus into the CLK domain: only the enable is
// synchronized, and its rising edge produces a one-cycle strobe that captures the bus.
module data_synchronizer #(
    parameter int data_width = 8,
    parameter int NUM_STAGES = 2
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [data_width-1:0] unsync_bus,
    input  logic                  bus_enable,
    output logic [data_width-1:0] sync_bus,
    output logic                  enable_pulse
);

    logic [NUM_STAGES-1:0] sync_chain;
    logic                  sync_en;
    logic                  sync_en_prev;
    logic                  pulse_comb;

    assign sync_en    = sync_chain[NUM_STAGES-1];
    assign pulse_comb = sync_en & ~sync_en_prev;

    // Enable synchronizer chain: bit 0 samples the asynchronous qualifier.
    always_ff @(posedge CLK) begin
        if (RST) begin
            sync_chain <= '0;
        end else begin
            sync_chain <= {sync_chain[NUM_STAGES-2:0], bus_enable};
        end
    end

    // Rising-edge detector on the synchronized enable.
    always_ff @(posedge CLK) begin
        if (RST) begin
            sync_en_prev <= 1'b0;
            enable_pulse <= 1'b0;
        end else begin
            sync_en_prev <= sync_en;
            enable_pulse <= pulse_comb;
        end
    end

    // The bus is stable while the qualifier is high, so sampling it once on
    // the detected edge is safe without passing it through the chain.
    always_ff @(posedge CLK) begin
        if (RST) begin
            sync_bus <= '0;
        end else if (pulse_comb) begin
            sync_bus <= unsync_bus;
        end
    end

endmodule

// File: tb/tb_data_synchronizer.sv
// Scoreboard bench for data_synchronizer: stimulus queues expected captures,
// a negedge monitor checks every enable_pulse against them.
module tb_data_synchronizer;

    logic       CLK;
    logic       RST;
    logic [7:0] unsync_bus;
    logic       bus_enable;
    logic [7:0] sync_bus;
    logic       enable_pulse;

    typedef struct {
        logic [7:0] data;
        int         cyc;
    } exp_t;

    exp_t exp_q[$];
    int   cyc    = 0;
    int   checks = 0;
    int   passed = 0;

    data_synchronizer #(.data_width(8), .NUM_STAGES(2)) dut (
        .CLK         (CLK),
        .RST         (RST),
        .unsync_bus  (unsync_bus),
        .bus_enable  (bus_enable),
        .sync_bus    (sync_bus),
        .enable_pulse(enable_pulse)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    always @(posedge CLK) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] required);
        checks++;
        if (actual === required) passed++;
        else $display("FAIL %s: got %0h, expected %0h", name, actual, required);
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    // Inputs driven now are sampled on the next edge; with two stages the
    // strobe is visible after the third edge from here.
    task automatic expect_pulse(input logic [7:0] data);
        exp_t e;
        e.data = data;
        e.cyc  = cyc + 3;
        exp_q.push_back(e);
    endtask

    always @(negedge CLK) begin
        if (enable_pulse === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("unexpected_pulse_cycle", cyc, 32'hFFFF_FFFF);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("pulse_data", {24'h0, sync_bus}, {24'h0, e.data});
                check("pulse_cycle", cyc, e.cyc);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        RST        = 1'b1;
        unsync_bus = 8'hAA;
        bus_enable = 1'b0;
        tick(1);
        check("reset_sync_bus", {24'h0, sync_bus}, 32'h00);
        check("reset_pulse", {31'h0, enable_pulse}, 32'h0);
        tick(1);
        RST = 1'b0;
        tick(2);

        // first capture, then hold one cycle after enable falls
        bus_enable = 1'b1;
        expect_pulse(8'hAA);
        tick(4);
        bus_enable = 1'b0;
        tick(1);
        check("hold_after_fall", {24'h0, sync_bus}, 32'hAA);
        tick(4);

        unsync_bus = 8'hF0;
        bus_enable = 1'b1;
        expect_pulse(8'hF0);
        tick(4);
        bus_enable = 1'b0;
        tick(4);
        check("second_capture", {24'h0, sync_bus}, 32'hF0);

        // bus changes with enable low must be ignored
        unsync_bus = 8'h55;
        tick(6);
        check("no_enable_bus", {24'h0, sync_bus}, 32'hF0);
        check("no_enable_pulse", {31'h0, enable_pulse}, 32'h0);

        unsync_bus = 8'h3C;
        bus_enable = 1'b1;
        expect_pulse(8'h3C);
        tick(20);
        bus_enable = 1'b0;
        tick(4);
        check("long_enable_bus", {24'h0, sync_bus}, 32'h3C);

        // enable low for exactly one sampled edge still gives a new pulse
        unsync_bus = 8'h81;
        bus_enable = 1'b1;
        expect_pulse(8'h81);
        tick(5);
        bus_enable = 1'b0;
        tick(1);
        unsync_bus = 8'h7E;
        bus_enable = 1'b1;
        expect_pulse(8'h7E);
        tick(5);
        bus_enable = 1'b0;
        tick(4);
        check("regap_capture", {24'h0, sync_bus}, 32'h7E);

        // reset on the second edge after enable rises
        unsync_bus = 8'hC3;
        bus_enable = 1'b1;
        tick(1);
        RST = 1'b1;
        tick(1);
        check("midsync_reset_bus", {24'h0, sync_bus}, 32'h00);
        check("midsync_reset_pulse", {31'h0, enable_pulse}, 32'h0);
        RST = 1'b0;
        expect_pulse(8'hC3);
        tick(5);
        bus_enable = 1'b0;
        tick(4);
        check("post_reset_capture", {24'h0, sync_bus}, 32'hC3);

        // reset lands on the very edge that would capture
        unsync_bus = 8'h5A;
        bus_enable = 1'b1;
        tick(2);
        RST = 1'b1;
        tick(1);
        check("reset_priority_bus", {24'h0, sync_bus}, 32'h00);
        check("reset_priority_pulse", {31'h0, enable_pulse}, 32'h0);
        RST = 1'b0;
        expect_pulse(8'h5A);
        tick(5);
        bus_enable = 1'b0;
        tick(4);
        check("priority_recapture", {24'h0, sync_bus}, 32'h5A);

        tick(4);
        check("pending_pulses", exp_q.size(), 32'h0);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/data_synchronizer.md
DATA_SYNCHRONIZER -- requirements
Module: data_synchronizer

Interface
REQ-001 The block SHALL have one clock, CLK; reset RST SHALL be synchronous and active-high.
REQ-002 Parameter data_width, default 8: width of unsync_bus and sync_bus.
REQ-003 Parameter NUM_STAGES, default 2: enable synchronizer depth; legal range 2..4.
REQ-004 Port CLK, input, 1, destination-domain clock; all flops on rising edge.
REQ-005 Port RST, input, 1, synchronous active-high reset sampled on CLK rising edge.
REQ-006 Port unsync_bus, input, data_width, source-domain data; stable whenever bus_enable is high.
REQ-007 Port bus_enable, input, 1, source-domain level qualifier; high means unsync_bus is valid.
REQ-008 Port sync_bus, output, data_width, registered data captured in the CLK domain.
REQ-009 Port enable_pulse, output, 1, registered single-cycle strobe marking a sync_bus update.

Function
REQ-010 bus_enable SHALL pass through a chain of NUM_STAGES flops; the last stage output is sync_en.
REQ-011 unsync_bus SHALL never pass through the multi-flop chain; it SHALL only be sampled under the synchronized qualifier.
REQ-012 A pulse-generator flop SHALL hold the previous sync_en; pulse_comb = sync_en AND NOT previous sync_en (rising edge only).
REQ-013 enable_pulse SHALL be a register loaded with pulse_comb each cycle.
REQ-014 sync_bus SHALL be loaded with unsync_bus on the same edge that loads enable_pulse with 1, and SHALL hold its value otherwise.
REQ-015 Latency: first CLK edge sampling bus_enable=1 is edge E; enable_pulse and the updated sync_bus SHALL appear after edge E+NUM_STAGES (NUM_STAGES+1 edges total; 3 edges with the default).
REQ-016 enable_pulse SHALL be high for exactly one CLK cycle per low-to-high transition of bus_enable, however long bus_enable stays high.
REQ-017 bus_enable held low SHALL produce no pulse, and sync_bus SHALL ignore any unsync_bus change.
REQ-018 A bus_enable high pulse shorter than one CLK period MAY be missed; when it is sampled, it SHALL produce exactly one pulse.
REQ-019 bus_enable falling then rising again SHALL produce a new pulse if the low level was sampled by at least one CLK edge at the chain input.
REQ-020 sync_bus SHALL keep its last captured value after bus_enable falls until the next capture.

Reset
REQ-021 With RST=1 at a CLK edge, all synchronizer stages, the pulse-generator flop, enable_pulse and sync_bus SHALL clear to 0.
REQ-022 RST SHALL take priority over any capture in the same cycle.
REQ-023 After RST falls with bus_enable already high, a pulse SHALL be generated NUM_STAGES+1 edges later, because the chain restarts from 0.
REQ-024 Reset asserted mid-synchronization SHALL abort the pending pulse, with no partial update of sync_bus.

Verification
REQ-025 Reset: RST=1 for one cycle with unsync_bus=8'hAA -> sync_bus=8'h00 and enable_pulse=0 on the next edge.
REQ-026 Capture: unsync_bus=8'hAA, bus_enable=1 for 4 cycles -> enable_pulse high for exactly one cycle after the 3rd edge, and sync_bus=8'hAA from then on, including one cycle after bus_enable falls.
REQ-027 Second capture: unsync_bus=8'hF0, bus_enable=1 for 4 cycles -> a single pulse, sync_bus=8'hF0.
REQ-028 No enable: with bus_enable=0, change unsync_bus from 8'hF0 to 8'h55 -> sync_bus stays 8'hF0 and enable_pulse stays 0.
REQ-029 Long enable: bus_enable=1 for 20 cycles -> exactly one enable_pulse cycle.
REQ-030 Reset mid-operation: bus_enable rises, RST=1 on the 2nd edge -> no pulse, sync_bus=8'h00; after RST falls with bus_enable still high -> pulse after 3 edges, sync_bus=unsync_bus.
